// File: rtl/spart_bridge_pkg.sv
// Shared types and defaults for the SPART <-> SDRAM bridge.
package spart_bridge_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 23;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_REQ  = 2'd1,
      RD_REQ  = 2'd2,
      RD_WAIT = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

endpackage

// File: rtl/spart_word_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is accepted only alongside a pop.
module spart_word_fifo
   import spart_bridge_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 8,
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [PTR_W:0]    level
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (PTR_W+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // NOTE: storage is left unreset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/spart_sdram_bridge.sv
// Bridges the SPART word streams to one SDRAM request port: buffered sequential writes,
// on-demand sequential reads, round-robin arbitration between the two.
module spart_sdram_bridge
   import spart_bridge_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           in_word,
   input  logic                        in_valid,
   input  logic [ADDR_W-1:0]           max_words,
   input  logic                        start_tx,
   input  logic                        rd_req,
   output logic [DATA_W-1:0]           out_word,
   output logic                        out_valid,
   output logic [ADDR_W-1:0]           sd_addr,
   output logic [DATA_W-1:0]           sd_wr_data,
   output logic                        sd_wr_req,
   output logic                        sd_rd_req,
   input  logic                        sd_ack,
   input  logic [DATA_W-1:0]           sd_rd_data,
   input  logic                        sd_rd_valid,
   output logic                        rx_done,
   output logic                        tx_done,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   state_t            state;
   grant_t            last_grant;
   logic              rd_pend;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [ADDR_W-1:0] rd_addr_nxt;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              rd_done;

   // max_words == 0 compares equal only at the natural 2^ADDR_W rollover.
   assign wr_addr_nxt = wr_addr + 1'b1;
   assign rd_addr_nxt = rd_addr + 1'b1;
   assign fifo_pop    = (state == WR_REQ) && sd_ack;
   assign rd_done     = sd_rd_valid && ((state == RD_WAIT) || ((state == RD_REQ) && sd_ack));

   spart_word_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (in_valid),
      .pop    (fifo_pop),
      .wr_data(in_word),
      .rd_data(fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GRANT_RD;
         rd_pend    <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         out_word   <= '0;
         out_valid  <= 1'b0;
         sd_addr    <= '0;
         sd_wr_data <= '0;
         sd_wr_req  <= 1'b0;
         sd_rd_req  <= 1'b0;
         rx_done    <= 1'b0;
         tx_done    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid && fifo_full && !fifo_pop) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (!fifo_empty && (!rd_pend || last_grant == GRANT_RD)) begin
                  state      <= WR_REQ;
                  sd_wr_req  <= 1'b1;
                  sd_addr    <= wr_addr;
                  sd_wr_data <= fifo_head;
               end else if (rd_pend) begin
                  state     <= RD_REQ;
                  sd_rd_req <= 1'b1;
                  sd_addr   <= start_tx ? '0 : rd_addr;
               end
            end
            WR_REQ: begin
               if (sd_ack) begin
                  state      <= IDLE;
                  sd_wr_req  <= 1'b0;
                  sd_addr    <= '0;
                  sd_wr_data <= '0;
                  last_grant <= GRANT_WR;
                  if (wr_addr_nxt == max_words) begin
                     wr_addr <= '0;
                     rx_done <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr_nxt;
                  end
               end
            end
            RD_REQ: begin
               if (sd_ack) begin
                  state      <= sd_rd_valid ? IDLE : RD_WAIT;
                  sd_rd_req  <= 1'b0;
                  sd_addr    <= '0;
                  rd_pend    <= 1'b0;
                  last_grant <= GRANT_RD;
               end
            end
            RD_WAIT: begin
               if (sd_rd_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (rd_done) begin
            out_word  <= sd_rd_data;
            out_valid <= 1'b1;
            if (rd_addr_nxt == max_words) begin
               rd_addr <= '0;
               tx_done <= 1'b1;
            end else begin
               rd_addr <= rd_addr_nxt;
            end
         end

         // A restart overrides any in-flight address update; a repeat rd_req never queues.
         if (start_tx) begin
            rd_pend <= 1'b1;
            rd_addr <= '0;
            tx_done <= 1'b0;
         end else if (rd_req && !rd_pend) begin
            rd_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spart_sdram_bridge.sv
// Self-checking bench: SDRAM responder with random latencies plus a sequential-address reference model.
module tb_spart_sdram_bridge;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 23;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [DATA_W-1:0] in_word = '0;
   logic              in_valid = 1'b0;
   logic [ADDR_W-1:0] max_words = '0;
   logic              start_tx = 1'b0;
   logic              rd_req = 1'b0;
   logic [DATA_W-1:0] out_word;
   logic              out_valid;
   logic [ADDR_W-1:0] sd_addr;
   logic [DATA_W-1:0] sd_wr_data;
   logic              sd_wr_req;
   logic              sd_rd_req;
   logic              sd_ack;
   logic [DATA_W-1:0] sd_rd_data;
   logic              sd_rd_valid;
   logic              rx_done;
   logic              tx_done;
   logic              overflow;
   logic [3:0]        fifo_level;

   always #5 clk = ~clk;

   spart_sdram_bridge #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .max_words  (max_words),
      .start_tx   (start_tx),
      .rd_req     (rd_req),
      .out_word   (out_word),
      .out_valid  (out_valid),
      .sd_addr    (sd_addr),
      .sd_wr_data (sd_wr_data),
      .sd_wr_req  (sd_wr_req),
      .sd_rd_req  (sd_rd_req),
      .sd_ack     (sd_ack),
      .sd_rd_data (sd_rd_data),
      .sd_rd_valid(sd_rd_valid),
      .rx_done    (rx_done),
      .tx_done    (tx_done),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] rd_pattern(input logic [ADDR_W-1:0] a);
      return 16'hA000 + a[15:0];
   endfunction

   // Responder controls and observation logs
   bit          ack_hold = 1'b0;
   bit          ack_rand = 1'b0;
   int          ack_delay = 2;
   bit          rd_rand = 1'b0;
   int          rd_lat = 1;
   bit          force_rd_valid = 1'b0;
   int          excl_viol = 0;
   int          idle_viol = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] rd_addr_q[$];
   logic [31:0] got_q[$];
   byte         order_q[$];

   initial begin : sdram_model
      int          wait_cnt;
      int          resp_cnt;
      int          lat;
      bit          in_req;
      bit          resp_pend;
      logic [ADDR_W-1:0] resp_addr;
      in_req = 0; resp_pend = 0; wait_cnt = 0; resp_cnt = 0; resp_addr = '0;
      sd_ack = 1'b0; sd_rd_valid = 1'b0; sd_rd_data = '0;
      forever begin
         @(negedge clk);
         sd_ack = 1'b0;
         sd_rd_valid = 1'b0;
         if (sd_wr_req && sd_rd_req) excl_viol++;
         if (!sd_wr_req && !sd_rd_req && sd_addr != '0) idle_viol++;
         if (out_valid) got_q.push_back(32'(out_word));
         if (force_rd_valid) begin
            sd_rd_valid = 1'b1;
            sd_rd_data = 16'hDEAD;
            force_rd_valid = 1'b0;
         end
         if (!rst) begin
            in_req = 0;
            resp_pend = 0;
         end else begin
            if (resp_pend) begin
               resp_cnt--;
               if (resp_cnt == 0) begin
                  sd_rd_valid = 1'b1;
                  sd_rd_data = rd_pattern(resp_addr);
                  resp_pend = 0;
               end
            end
            if (sd_wr_req || sd_rd_req) begin
               if (!in_req) begin
                  in_req = 1;
                  wait_cnt = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
               end
               if (!ack_hold) begin
                  if (wait_cnt == 0) begin
                     sd_ack = 1'b1;
                     in_req = 0;
                     if (sd_wr_req) begin
                        wr_addr_q.push_back(32'(sd_addr));
                        wr_data_q.push_back(32'(sd_wr_data));
                        order_q.push_back("W");
                     end else begin
                        rd_addr_q.push_back(32'(sd_addr));
                        order_q.push_back("R");
                        lat = rd_rand ? int'($urandom_range(0, 2)) : rd_lat;
                        if (lat == 0) begin
                           sd_rd_valid = 1'b1;
                           sd_rd_data = rd_pattern(sd_addr);
                        end else begin
                           resp_pend = 1;
                           resp_cnt = lat;
                           resp_addr = sd_addr;
                        end
                     end
                  end else begin
                     wait_cnt--;
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0; start_tx = 1'b0; rd_req = 1'b0; force_rd_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      got_q.delete(); order_q.delete();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      in_word = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_rd();
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic pulse_start();
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
   endtask

   task automatic wait_wr(input int n);
      for (int i = 0; i < 300 && wr_data_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_got(input int n);
      for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_word"},  32'(out_word), 0);
      check({tag, "_sd_addr"},   32'(sd_addr), 0);
      check({tag, "_sd_wr_data"}, 32'(sd_wr_data), 0);
      check({tag, "_reqs"},      {30'd0, sd_wr_req, sd_rd_req}, 0);
      check({tag, "_flags"},     {29'd0, rx_done, tx_done, overflow}, 0);
      check({tag, "_level"},     32'(fifo_level), 0);
   endtask

   initial begin : main
      logic [31:0] exp_wa[$];
      logic [31:0] exp_wd[$];
      logic [31:0] exp_rd[$];
      logic [15:0] w;
      string       exp_order;
      int          mw;
      int          model_wa;
      int          model_ra;

      // Reset state
      max_words = 23'd4;
      do_reset();
      check_outputs_zero("reset");

      // Write path, fixed 2-cycle ack
      ack_rand = 0; ack_delay = 2; rd_rand = 0; rd_lat = 1;
      push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
      wait_wr(3);
      check("rx_done_before_4th", 32'(rx_done), 0);
      wait_wr(4);
      repeat (2) @(negedge clk);
      check("wr_count", wr_data_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wr_addr%0d", i), wr_addr_q[i], i);
         check($sformatf("wr_data%0d", i), wr_data_q[i], 32'h1111 * (i + 1));
      end
      check("rx_done_after_4th", 32'(rx_done), 1);
      push_word(16'h5555);
      wait_wr(5);
      check("wr_addr_wrapped", wr_addr_q[4], 0);

      // Overflow: ack held, nine pushes into eight entries
      max_words = '0;
      do_reset();
      ack_hold = 1;
      exp_wd.delete();
      for (int i = 0; i < 9; i++) begin
         w = 16'($urandom);
         exp_wd.push_back(32'(w));
         push_word(w);
      end
      repeat (2) @(negedge clk);
      check("ovf_level", 32'(fifo_level), 8);
      check("ovf_flag", 32'(overflow), 1);
      ack_hold = 0;
      wait_wr(8);
      repeat (30) @(negedge clk);
      check("ovf_wr_count", wr_data_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovf_data%0d", i), wr_data_q[i], exp_wd[i]);
         check($sformatf("ovf_addr%0d", i), wr_addr_q[i], i);
      end
      check("ovf_level_drained", 32'(fifo_level), 0);

      // Readback with random ack/data latency
      max_words = 23'd4;
      do_reset();
      ack_rand = 1; rd_rand = 1;
      pulse_start();
      wait_got(1);
      for (int k = 1; k < 4; k++) begin
         if (k == 3) check("tx_done_before_4th", 32'(tx_done), 0);
         pulse_rd();
         wait_got(k + 1);
      end
      @(negedge clk);
      check("rd_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rd_word%0d", i), got_q[i], 32'hA000 + i);
         check($sformatf("rd_addr%0d", i), rd_addr_q[i], i);
      end
      check("tx_done_after_4th", 32'(tx_done), 1);
      pulse_start();
      check("tx_done_cleared", 32'(tx_done), 0);
      wait_got(5);
      check("restart_word", got_q[4], 32'hA000);
      check("restart_addr", rd_addr_q[4], 0);

      // Arbitration: three queued writes then a read
      max_words = '0;
      do_reset();
      ack_rand = 0; ack_delay = 2; rd_rand = 0; rd_lat = 1;
      push_word(16'h0A01); push_word(16'h0A02); push_word(16'h0A03);
      pulse_rd();
      wait_wr(3);
      wait_got(1);
      repeat (5) @(negedge clk);
      exp_order = "WRWW";
      check("arb_count", order_q.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("arb_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

      // start_tx with rd_req together, then rd_req while pending
      max_words = 23'd8;
      do_reset();
      pulse_start();
      wait_got(1);
      pulse_rd();
      wait_got(2);
      start_tx = 1'b1; rd_req = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      @(negedge clk);
      rd_req = 1'b0;
      wait_got(3);
      repeat (20) @(negedge clk);
      check("simul_reads", rd_addr_q.size(), 3);
      check("simul_addr", rd_addr_q[2], 0);
      check("simul_word", got_q[2], 32'hA000);
      check("simul_outputs", got_q.size(), 3);

      // Reset while waiting for read data
      max_words = 23'd8;
      do_reset();
      ack_delay = 0; rd_lat = 4;
      pulse_start();
      for (int i = 0; i < 50 && rd_addr_q.size() < 1; i++) @(negedge clk);
      check("midrst_read_issued", rd_addr_q.size(), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_outputs_zero("midrst_async");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      force_rd_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_out_valid", got_q.size(), 0);
      check_outputs_zero("midrst_after");

      // Random mixed traffic against the sequential-address model
      mw = int'($urandom_range(3, 6));
      max_words = ADDR_W'(mw);
      do_reset();
      ack_rand = 1; rd_rand = 1;
      model_wa = 0; model_ra = 0;
      exp_wa.delete(); exp_wd.delete(); exp_rd.delete();
      for (int r = 0; r < 12; r++) begin
         int burst;
         int rd_at;
         burst = int'($urandom_range(1, 8));
         rd_at = int'($urandom_range(0, burst));
         for (int i = 0; i <= burst; i++) begin
            if (i < burst) begin
               w = 16'($urandom);
               in_word = w;
               in_valid = 1'b1;
               exp_wa.push_back(32'(model_wa));
               exp_wd.push_back(32'(w));
               model_wa = (model_wa + 1 == mw) ? 0 : model_wa + 1;
            end
            if (i == rd_at) begin
               rd_req = 1'b1;
               exp_rd.push_back(32'(rd_pattern(ADDR_W'(model_ra))));
               model_ra = (model_ra + 1 == mw) ? 0 : model_ra + 1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            rd_req = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_wr(exp_wd.size());
         wait_got(exp_rd.size());
      end
      repeat (10) @(negedge clk);
      check("rand_wr_count", wr_data_q.size(), exp_wd.size());
      check("rand_rd_count", got_q.size(), exp_rd.size());
      foreach (exp_wd[i]) begin
         check($sformatf("rand_wr_addr%0d", i), wr_addr_q[i], exp_wa[i]);
         check($sformatf("rand_wr_data%0d", i), wr_data_q[i], exp_wd[i]);
      end
      foreach (exp_rd[i]) check($sformatf("rand_rd_word%0d", i), got_q[i], exp_rd[i]);
      check("rand_rx_done", 32'(rx_done), 32'(exp_wd.size() >= mw));
      check("rand_tx_done", 32'(tx_done), 32'(exp_rd.size() >= mw));
      check("rand_overflow", 32'(overflow), 0);
      check("req_exclusive", excl_viol, 0);
      check("idle_addr_zero", idle_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
